// File: rtl/gate_selftest_ctrl_pkg.sv
// Shared types and constants for the gate-unit self-test sequencer:
// state encoding, gate_out bit packing and the golden truth table.
package gate_selftest_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DRIVE,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    // gate_out packing, shared with the gate unit wrapper
    localparam int unsigned BIT_AND   = 0;
    localparam int unsigned BIT_OR    = 1;
    localparam int unsigned BIT_NOT_A = 2;
    localparam int unsigned BIT_NOT_B = 3;
    localparam int unsigned BIT_NAND  = 4;
    localparam int unsigned BIT_NOR   = 5;
    localparam int unsigned BIT_XOR   = 6;
    localparam int unsigned BIT_XNOR  = 7;

    localparam logic [7:0] GOLD_00 = 8'hBC;
    localparam logic [7:0] GOLD_01 = 8'h56;
    localparam logic [7:0] GOLD_10 = 8'h5A;
    localparam logic [7:0] GOLD_11 = 8'h83;

    function automatic logic [7:0] golden(input logic [1:0] v);
        logic [7:0] g;
        case (v)
            2'd0:    g = GOLD_00;
            2'd1:    g = GOLD_01;
            2'd2:    g = GOLD_10;
            default: g = GOLD_11;
        endcase
        return g;
    endfunction

    function automatic logic [3:0] popcount8(input logic [7:0] x);
        logic [3:0] cnt;
        cnt = '0;
        for (int unsigned i = 0; i < 8; i++) begin
            cnt = cnt + 4'(x[i]);
        end
        return cnt;
    endfunction

endpackage

// File: rtl/gate_selftest_ctrl.sv
// Self-test sequencer: walks the gate unit through all four a/b vectors,
// compares the eight outputs to the golden table and reports the result.
module gate_selftest_ctrl
    import gate_selftest_ctrl_pkg::*;
#(
    parameter int unsigned SETTLE_CYC = 2,
    parameter int unsigned ERR_W      = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             abort,
    output logic             gate_a,
    output logic             gate_b,
    input  logic [7:0]       gate_out,
    output logic             busy,
    output logic             done,
    output logic             pass,
    output logic [ERR_W-1:0] err_cnt,
    output logic [1:0]       fail_vec,
    output logic [7:0]       fail_obs
);

    localparam logic [ERR_W-1:0] ERR_MAX = '1;

    state_t           state, state_n;
    logic [1:0]       vec, vec_n;
    logic [7:0]       timer, timer_n;
    logic             seen, seen_n;
    logic [ERR_W-1:0] err_n;
    logic             pass_n;
    logic [1:0]       fvec_n;
    logic [7:0]       fobs_n;
    logic             busy_n;
    logic [7:0]       mism;
    logic [ERR_W+3:0] sum;
    logic [ERR_W-1:0] err_sat;

    always_comb begin
        mism    = gate_out ^ golden(vec);
        sum     = (ERR_W+4)'(err_cnt) + (ERR_W+4)'(popcount8(mism));
        err_sat = (sum > (ERR_W+4)'(ERR_MAX)) ? ERR_MAX : sum[ERR_W-1:0];
    end

    always_comb begin
        state_n = state;
        vec_n   = vec;
        timer_n = timer;
        seen_n  = seen;
        err_n   = err_cnt;
        pass_n  = pass;
        fvec_n  = fail_vec;
        fobs_n  = fail_obs;

        case (state)
            ST_IDLE: begin
                if (start && !abort) begin
                    state_n = ST_DRIVE;
                    vec_n   = '0;
                    err_n   = '0;
                    pass_n  = 1'b0;
                    fvec_n  = '0;
                    fobs_n  = '0;
                    seen_n  = 1'b0;
                end
            end
            ST_DRIVE: begin
                if (abort) begin
                    state_n = ST_IDLE;
                    pass_n  = 1'b0;
                end else begin
                    timer_n = 8'(SETTLE_CYC - 1);
                    state_n = ST_SETTLE;
                end
            end
            ST_SETTLE: begin
                if (abort) begin
                    state_n = ST_IDLE;
                    pass_n  = 1'b0;
                end else if (timer == '0) begin
                    state_n = ST_CHECK;
                end else begin
                    timer_n = timer - 8'd1;
                end
            end
            ST_CHECK: begin
                if (abort) begin
                    state_n = ST_IDLE;
                    pass_n  = 1'b0;
                end else begin
                    err_n = err_sat;
                    if ((mism != '0) && !seen) begin
                        fvec_n = vec;
                        fobs_n = gate_out;
                        seen_n = 1'b1;
                    end
                    if (vec == 2'd3) begin
                        state_n = ST_DONE;
                        pass_n  = (err_sat == '0);
                    end else begin
                        vec_n   = vec + 2'd1;
                        state_n = ST_DRIVE;
                    end
                end
            end
            ST_DONE:  state_n = ST_IDLE;
            default:  state_n = ST_IDLE;
        endcase

        busy_n = (state_n == ST_DRIVE) || (state_n == ST_SETTLE) || (state_n == ST_CHECK);
    end

    // Visible outputs are registered from next-state values so they line up with the state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= ST_IDLE;
            vec      <= '0;
            timer    <= '0;
            seen     <= 1'b0;
            err_cnt  <= '0;
            pass     <= 1'b0;
            fail_vec <= '0;
            fail_obs <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
            gate_a   <= 1'b0;
            gate_b   <= 1'b0;
        end else begin
            state    <= state_n;
            vec      <= vec_n;
            timer    <= timer_n;
            seen     <= seen_n;
            err_cnt  <= err_n;
            pass     <= pass_n;
            fail_vec <= fvec_n;
            fail_obs <= fobs_n;
            busy     <= busy_n;
            done     <= (state_n == ST_DONE);
            gate_a   <= busy_n & vec_n[1];
            gate_b   <= busy_n & vec_n[0];
        end
    end

endmodule

// File: tb/tb_gate_selftest_ctrl.sv
// Bench for gate_selftest_ctrl: behavioural gate unit with per-vector fault masks,
// expected results queued at start and checked by a monitor on each done pulse.
module tb_gate_selftest_ctrl;

    localparam int unsigned SETTLE = 2;
    localparam int unsigned LAT    = 4 * (SETTLE + 2);

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start = 1'b0;
    logic       abort = 1'b0;
    logic       gate_a, gate_b;
    logic [7:0] gate_out;
    logic       busy, done, pass;
    logic [3:0] err_cnt;
    logic [1:0] fail_vec;
    logic [7:0] fail_obs;

    logic [7:0] mask [4];
    int         cyc = 0;
    int         checks = 0;
    int         errors = 0;

    typedef struct {
        logic       pass;
        logic [3:0] err;
        logic [1:0] fvec;
        logic [7:0] fobs;
        int         done_cyc;
    } exp_t;

    exp_t sb[$];
    int   seq[$];

    gate_selftest_ctrl #(.SETTLE_CYC(SETTLE), .ERR_W(4)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (start),
        .abort    (abort),
        .gate_a   (gate_a),
        .gate_b   (gate_b),
        .gate_out (gate_out),
        .busy     (busy),
        .done     (done),
        .pass     (pass),
        .err_cnt  (err_cnt),
        .fail_vec (fail_vec),
        .fail_obs (fail_obs)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Fault-free all-gates unit, packed {xnor,xor,nor,nand,not_b,not_a,or,and}
    function automatic logic [7:0] gate_unit(input logic a, input logic b);
        return {~(a ^ b), a ^ b, ~(a | b), ~(a & b), ~b, ~a, a | b, a & b};
    endfunction

    assign gate_out = gate_unit(gate_a, gate_b) ^ mask[{gate_a, gate_b}];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 32'(done), 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("done_latency", 32'(cyc), 32'(e.done_cyc));
                chk("pass", 32'(pass), 32'(e.pass));
                chk("err_cnt", 32'(err_cnt), 32'(e.err));
                chk("fail_vec", 32'(fail_vec), 32'(e.fvec));
                chk("fail_obs", 32'(fail_obs), 32'(e.fobs));
                chk("busy_in_done", 32'(busy), 32'd0);
                chk("vec_seq", {seq.size() == 4 ? seq[0] : -1, seq.size() == 4 ? seq[3] : -1} == {32'sd0, 32'sd3} &&
                    seq.size() == 4 && seq[1] == 1 && seq[2] == 2 ? 32'd1 : 32'd0, 32'd1);
            end
            seq.delete();
        end else if (busy) begin
            if (seq.size() == 0 || seq[$] != int'({gate_a, gate_b}))
                seq.push_back(int'({gate_a, gate_b}));
        end else begin
            seq.delete();
        end
    end

    task automatic set_masks(input logic [7:0] m0, input logic [7:0] m1,
                             input logic [7:0] m2, input logic [7:0] m3);
        mask[0] = m0; mask[1] = m1; mask[2] = m2; mask[3] = m3;
    endtask

    // Reference: total differing bits saturating at 15, first faulty vector captured.
    task automatic issue_start(input bit push);
        exp_t e;
        int   total;
        bit   found;
        @(negedge clk);
        total = 0;
        found = 0;
        e.fvec = '0;
        e.fobs = '0;
        for (int v = 0; v < 4; v++) begin
            logic [1:0] vv;
            vv = 2'(v);
            total += $countones(mask[v]);
            if (mask[v] != 8'h00 && !found) begin
                found = 1;
                e.fvec = vv;
                e.fobs = gate_unit(vv[1], vv[0]) ^ mask[v];
            end
        end
        e.err = (total > 15) ? 4'd15 : 4'(total);
        e.pass = (total == 0);
        e.done_cyc = cyc + 1 + int'(LAT);
        if (push) sb.push_back(e);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((sb.size() != 0 || busy) && n < 80) begin
            @(negedge clk);
            n++;
        end
        if (n >= 80) chk("run_timeout", 32'd1, 32'd0);
    endtask

    initial begin
        set_masks(8'h00, 8'h00, 8'h00, 8'h00);
        #2;
        chk("reset_outputs", {19'd0, busy, done, pass, gate_a, gate_b, err_cnt, fail_vec, fail_obs[0]},
            32'd0);
        chk("reset_fail_obs", 32'(fail_obs), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // clean run
        issue_start(1);
        wait_idle();

        // AND stuck-at-0
        set_masks(8'h00, 8'h00, 8'h00, 8'h01);
        issue_start(1);
        wait_idle();

        // outputs forced to zero
        set_masks(8'hBC, 8'h56, 8'h5A, 8'h83);
        issue_start(1);
        wait_idle();

        // abort during SETTLE of vec 2
        set_masks(8'h00, 8'h00, 8'h00, 8'h00);
        issue_start(0);
        begin
            int n = 0;
            while (!(gate_a && !gate_b) && n < 40) begin
                @(negedge clk);
                n++;
            end
            if (n >= 40) chk("abort_wait_timeout", 32'd1, 32'd0);
        end
        @(negedge clk);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk("abort_busy", 32'(busy), 32'd0);
        chk("abort_ab", 32'({gate_a, gate_b}), 32'd0);
        chk("abort_done", 32'(done), 32'd0);
        chk("abort_pass", 32'(pass), 32'd0);
        repeat (3) @(negedge clk);
        issue_start(1);
        wait_idle();

        // reset in the middle of CHECK
        set_masks(8'hFF, 8'h00, 8'h00, 8'h00);
        issue_start(0);
        repeat (3) @(posedge clk);
        #2;
        chk("busy_before_reset", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {17'd0, busy, done, pass, gate_a, gate_b, err_cnt, fail_vec, 4'd0}, 32'd0);
        chk("async_reset_fail_obs", 32'(fail_obs), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        set_masks(8'h00, 8'h10, 8'h00, 8'h00);
        issue_start(1);
        wait_idle();

        // start held high across a whole run: exactly one run
        set_masks(8'h00, 8'h00, 8'h00, 8'h00);
        issue_start(1);
        start = 1'b1;
        repeat (16) @(negedge clk);
        start = 1'b0;
        wait_idle();
        repeat (4) @(negedge clk);
        chk("held_start_single_run", 32'(busy), 32'd0);

        // start and abort together in IDLE
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        chk("start_abort_idle", 32'(busy), 32'd0);
        @(negedge clk);
        chk("start_abort_idle_ab", 32'({busy, gate_a, gate_b}), 32'd0);

        // randomized fault patterns
        for (int r = 0; r < 10; r++) begin
            for (int v = 0; v < 4; v++)
                mask[v] = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            issue_start(1);
            wait_idle();
            repeat ($urandom_range(0, 3)) @(negedge clk);
        end

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
